sram_controller: RTL and testbench
==================================

# sram_controller

Memory-side responder for the pipeline's MEM stage. It accepts the 32-bit load/store request the MEM stage issues (`mem_read`/`mem_write`, byte address, store data) and performs it as two sequential 16-bit halfword accesses to an external asynchronous SRAM. It holds `ready` low until the access completes; the top level uses `~ready` to freeze every pipeline register. Returned load data goes to the MEM register path.

## Interface
Parameters:
- `ADDR_OFFSET`, 1024: byte address that maps to SRAM halfword 0.
- `WAIT_CYCLES`, 2: clock cycles per halfword phase. Must be ≥2.

Ports:
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `mem_read` in 1: load request. Held stable until `ready`.
- `mem_write` in 1: store request. Held stable until `ready`. If both `mem_read` and `mem_write` are high, the access is a write.
- `address` in 32: byte address (the ALU result). Bits [1:0] are ignored.
- `wdata` in 32: store data (`val_Rm`).
- `rdata` out 32: load data. Registered.
- `ready` out 1: high when no request is pending, or in the cycle the request completes.
- `SRAM_DQ` inout 16: SRAM data bus.
- `SRAM_ADDR` out 18: halfword address.
- `SRAM_WE_N` out 1: write strobe, active-low.
- `SRAM_OE_N` out 1: output enable, active-low.
- `SRAM_CE_N`, `SRAM_UB_N`, `SRAM_LB_N` out 1 each: tied 0.
- `addr_err` out 1: present only with `SRAM_ADDR_CHECK_EN`.

## Operation
- Halfword index: `h = (address - ADDR_OFFSET) >> 1`, with bit 0 cleared.
  - Low phase: `SRAM_ADDR = h[17:0]`.
  - High phase: `SRAM_ADDR = h[17:0] | 1`.
  - Little-endian: the low half is `data[15:0]`.
- FSM states:
  - `IDLE`: if a request is present, latch address/data, go to `LO`, clear the phase counter.
  - `LO`: run `WAIT_CYCLES` cycles. On the final cycle, capture read data into `rdata[15:0]`, then go to `HI`.
  - `HI`: run `WAIT_CYCLES` cycles. On the final cycle, capture read data into `rdata[31:16]`, then go to `DONE`.
  - `DONE`: go to `IDLE` unconditionally.
- `ready = (state==DONE) | (state==IDLE & ~mem_read & ~mem_write)`. This is combinational from the state and the request inputs.
- Read phases:
  - `SRAM_OE_N=0`, `SRAM_WE_N=1`, `SRAM_DQ` tri-stated.
  - `rdata` holds its value until the next read completes. Writes never change `rdata`.
- Write phases:
  - `SRAM_OE_N=1`.
  - `SRAM_DQ` driven with the latched half for the whole phase.
  - `SRAM_WE_N=0` on every cycle of the phase except the first, so the address is set up one cycle before the strobe.
- The request is latched in `IDLE`. Changes to the inputs during `LO`/`HI` are ignored.
- In `DONE` the pipeline unfreezes. The next request is seen in `IDLE` the following cycle, so back-to-back accesses have one idle-ready gap.
- Outside any access: `SRAM_DQ` tri-stated, `SRAM_WE_N=1`, `SRAM_OE_N=1`.

## Timing
- Reset values:
  - state `IDLE`, `rdata=0`, `SRAM_ADDR=0`.
  - `SRAM_WE_N=1`, `SRAM_OE_N=1`, `SRAM_DQ=Z`.
  - `addr_err=0`.
  - `ready` = 1 while no request is present.
- Latency, request first seen at cycle 0:
  - `ready` is low for cycles 0 to 2·`WAIT_CYCLES`.
  - `ready` is high in cycle 2·`WAIT_CYCLES`+1 (`DONE`).
  - With the default `WAIT_CYCLES`=2: 6 cycles total, 5 of them frozen.
- `rdata` is valid in the `DONE` cycle, when `ready` is high.
- Reset asserted mid-access: immediate return to `IDLE`. `SRAM_WE_N` goes to 1 and `SRAM_DQ` goes to Z asynchronously. The partial write is abandoned.
- Address wrap: the subtraction is modulo 2^32, and only bits [18:1] of the difference are used.

## Configuration
- `SRAM_ADDR_CHECK_EN` defined:
  - A request with `address < ADDR_OFFSET` or `address ≥ ADDR_OFFSET + 2^19` performs no SRAM cycle.
  - The FSM goes `IDLE`→`DONE`, so `ready` is low for exactly 1 cycle.
  - `rdata` is set to 0 on an out-of-range read.
  - `addr_err` pulses high for the `DONE` cycle.
- `SRAM_ADDR_CHECK_EN` undefined:
  - No `addr_err` port.
  - Every address goes through the full access, using the wrapped index.

## Test plan
- Store `0xDEADBEEF` at 1024:
  - `SRAM_ADDR` is 0 then 1, with `DQ`=`0xBEEF` then `0xDEAD`.
  - `WE_N` is low for 1 cycle per phase.
  - `ready` goes high at cycle 5.
- Load from 1024 after that store, with an SRAM model behind the controller: `rdata=0xDEADBEEF` in the `DONE` cycle; `ready` is low for 5 cycles.
- Back-to-back store to 1028 then load from 1028:
  - The two accesses are separated by exactly one `IDLE` cycle.
  - The load returns the stored data.
- `mem_read` and `mem_write` both high at 1032 with `wdata=0x12345678`: a write is performed, and `rdata` is unchanged.
- `rst` driven low during the `LO` write phase:
  - `SRAM_WE_N`=1 and `DQ`=Z immediately.
  - Once `rst` is high again with no request present, `ready`=1 with no clock edge needed.
- With `SRAM_ADDR_CHECK_EN`, load from address 0:
  - `WE_N` and `OE_N` stay high.
  - `ready` is low 1 cycle.
  - `rdata=0` and `addr_err` is high for 1 cycle.

Source files
------------

// File: rtl/sram_controller.sv
// MEM-stage load/store responder: each 32-bit access becomes two 16-bit async SRAM phases.
// Optional build macro SRAM_ADDR_CHECK_EN rejects addresses outside the SRAM window.
module sram_controller #(
  parameter int unsigned ADDR_OFFSET = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N
`ifdef SRAM_ADDR_CHECK_EN
  ,
  output logic        addr_err
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LO   = 2'd1;
  localparam logic [1:0] HI   = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam int CW = (WAIT_CYCLES > 2) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);
  localparam logic [31:0] OFFSET = ADDR_OFFSET;

  logic [1:0]    state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [16:0]   hidx, hidx_nx;
  logic [31:0]   wdata_q, data_nx;
  logic          write_q, write_nx;
  logic          accept, phase_end, active_nx;
  logic          dq_oe;
  logic [15:0]   dq_out;

  assign accept    = (state == IDLE) && (mem_read || mem_write);
  assign phase_end = (cnt == LAST);
  assign ready     = (state == DONE) || ((state == IDLE) && !mem_read && !mem_write);

  // Halfword pair index keeps only bits [18:2] of the wrapped difference; bit 0 selects the phase.
  assign hidx_nx  = accept ? 17'((address - OFFSET) >> 2) : hidx;
  assign write_nx = accept ? mem_write : write_q;
  assign data_nx  = accept ? wdata : wdata_q;

`ifdef SRAM_ADDR_CHECK_EN
  logic out_of_range;
  assign out_of_range = (address < OFFSET) || ((address - OFFSET) >= 32'h0008_0000);
`endif

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          cnt_nx = '0;
`ifdef SRAM_ADDR_CHECK_EN
          state_nx = out_of_range ? DONE : LO;
`else
          state_nx = LO;
`endif
        end
      end
      LO: begin
        if (phase_end) begin
          state_nx = HI;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      HI: begin
        if (phase_end) begin
          state_nx = DONE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign active_nx = (state_nx == LO) || (state_nx == HI);

  // SRAM pins are registered from the next state so strobes never glitch; the first
  // cycle of each write phase keeps WE_N high to give address setup.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      hidx      <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      SRAM_ADDR <= '0;
      SRAM_OE_N <= 1'b1;
      SRAM_WE_N <= 1'b1;
      dq_oe     <= 1'b0;
      dq_out    <= '0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      hidx      <= hidx_nx;
      write_q   <= write_nx;
      wdata_q   <= data_nx;
      SRAM_ADDR <= {hidx_nx, state_nx == HI};
      SRAM_OE_N <= !(active_nx && !write_nx);
      SRAM_WE_N <= !(active_nx && write_nx && (cnt_nx != '0));
      dq_oe     <= active_nx && write_nx;
      dq_out    <= (state_nx == HI) ? data_nx[31:16] : data_nx[15:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata <= '0;
    end else if ((state == LO) && phase_end && !write_q) begin
      rdata[15:0] <= SRAM_DQ;
    end else if ((state == HI) && phase_end && !write_q) begin
      rdata[31:16] <= SRAM_DQ;
`ifdef SRAM_ADDR_CHECK_EN
    end else if (accept && out_of_range && !mem_write) begin
      rdata <= '0;
`endif
    end
  end

`ifdef SRAM_ADDR_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_err <= 1'b0;
    end else begin
      addr_err <= accept && out_of_range;
    end
  end
`endif

  assign SRAM_DQ   = dq_oe ? dq_out : 16'hzzzz;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;

endmodule

// File: tb/tb_sram_controller.sv
// Testbench for sram_controller: table of load/store transactions against a small SRAM model,
// plus hand-written reset-abort and (with SRAM_ADDR_CHECK_EN) out-of-range sequences.
module tb_sram_controller;

  localparam int W      = 2;
  localparam int DONE_C = 2 * W + 1;

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [17:0] h_lo;
    logic [31:0] exp_rdata;
    bit          b2b;
  } vec_t;

  logic        clk, rst, mem_read, mem_write;
  logic [31:0] address, wdata, rdata;
  logic        ready;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n;
`ifdef SRAM_ADDR_CHECK_EN
  logic        addr_err;
`endif

  logic [15:0] mem [0:1023];
  vec_t        vecs [16];
  int          nvec;
  int          checks;
  int          errors;

  sram_controller #(.ADDR_OFFSET(1024), .WAIT_CYCLES(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .address   (address),
    .wdata     (wdata),
    .rdata     (rdata),
    .ready     (ready),
    .SRAM_DQ   (sram_dq),
    .SRAM_ADDR (sram_addr),
    .SRAM_WE_N (sram_we_n),
    .SRAM_OE_N (sram_oe_n),
    .SRAM_CE_N (sram_ce_n),
    .SRAM_UB_N (sram_ub_n),
    .SRAM_LB_N (sram_lb_n)
`ifdef SRAM_ADDR_CHECK_EN
    ,
    .addr_err  (addr_err)
`endif
  );

  // An undriven bus floats high, so a tri-stated DQ reads back as 16'hFFFF.
  pullup (sram_dq);

  assign sram_dq = (!sram_oe_n && sram_we_n) ? mem[sram_addr[9:0]] : 16'hzzzz;

  always @(posedge clk) begin
    if (!sram_we_n) mem[sram_addr[9:0]] <= sram_dq;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string what, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", what, act, exp);
    end
  endtask

  task automatic addVec(input string name, input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [17:0] h_lo, input logic [31:0] exp_rdata,
                        input bit b2b);
    vecs[nvec] = '{name, rd, wr, addr, wd, h_lo, exp_rdata, b2b};
    nvec++;
  endtask

  task automatic idleCycle();
    @(posedge clk);
    #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    @(negedge clk);
    checkOutput("idle ready", 32'(ready), 32'd1);
  endtask

  // Issues one request and checks every cycle of it up to and including DONE.
  task automatic applyStimulus(input int i);
    vec_t v;
    logic active, hi, is_wr;
    int   p;
    v = vecs[i];
    @(posedge clk);
    #1;
    mem_read  = v.rd;
    mem_write = v.wr;
    address   = v.addr;
    wdata     = v.wdata;
    is_wr     = v.wr;
    for (int c = 0; c <= DONE_C; c++) begin
      @(negedge clk);
      active = (c >= 1) && (c <= 2 * W);
      hi     = (c > W);
      p      = hi ? (c - W - 1) : (c - 1);
      checkOutput($sformatf("%s c%0d ready", v.name, c), 32'(ready), 32'(c == DONE_C));
      checkOutput($sformatf("%s c%0d oe_n", v.name, c), 32'(sram_oe_n), 32'(!(active && !is_wr)));
      checkOutput($sformatf("%s c%0d we_n", v.name, c), 32'(sram_we_n),
                  32'(!(active && is_wr && (p != 0))));
      if (active)
        checkOutput($sformatf("%s c%0d addr", v.name, c), 32'(sram_addr), 32'(v.h_lo | 18'(hi)));
      if (active && is_wr)
        checkOutput($sformatf("%s c%0d dq", v.name, c), 32'(sram_dq),
                    32'(hi ? v.wdata[31:16] : v.wdata[15:0]));
    end
    checkOutput($sformatf("%s rdata", v.name), rdata, v.exp_rdata);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    nvec      = 0;
    rst       = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    address   = '0;
    wdata     = '0;

    addVec("st1024",   1'b0, 1'b1, 32'd1024,     32'hDEADBEEF, 18'h00000, 32'h00000000, 1'b0);
    addVec("ld1024",   1'b1, 1'b0, 32'd1024,     32'h0,        18'h00000, 32'hDEADBEEF, 1'b0);
    addVec("st1028",   1'b0, 1'b1, 32'd1028,     32'hCAFEF00D, 18'h00002, 32'hDEADBEEF, 1'b0);
    addVec("ld1028",   1'b1, 1'b0, 32'd1028,     32'h0,        18'h00002, 32'hCAFEF00D, 1'b1);
    addVec("rw1032",   1'b1, 1'b1, 32'd1032,     32'h12345678, 18'h00004, 32'hCAFEF00D, 1'b0);
    addVec("ld1032",   1'b1, 1'b0, 32'd1032,     32'h0,        18'h00004, 32'h12345678, 1'b0);
    addVec("ld1026",   1'b1, 1'b0, 32'd1026,     32'h0,        18'h00000, 32'hDEADBEEF, 1'b0);
    addVec("st_top",   1'b0, 1'b1, 32'h0008_03FC, 32'h0BADC0DE, 18'h3FFFE, 32'hDEADBEEF, 1'b0);
    addVec("ld_top",   1'b1, 1'b0, 32'h0008_03FC, 32'h0,        18'h3FFFE, 32'h0BADC0DE, 1'b0);
`ifndef SRAM_ADDR_CHECK_EN
    addVec("ld_wrap",  1'b1, 1'b0, 32'h0008_0404, 32'h0,        18'h00002, 32'hCAFEF00D, 1'b0);
    addVec("st_addr0", 1'b0, 1'b1, 32'h0000_0000, 32'h55AA1234, 18'h3FE00, 32'hCAFEF00D, 1'b0);
    addVec("ld_addr2", 1'b1, 1'b0, 32'h0000_0002, 32'h0,        18'h3FE00, 32'h55AA1234, 1'b0);
`endif

    @(negedge clk);
    checkOutput("reset rdata", rdata, 32'h0);
    checkOutput("reset sram_addr", 32'(sram_addr), 32'h0);
    checkOutput("reset we_n", 32'(sram_we_n), 32'd1);
    checkOutput("reset oe_n", 32'(sram_oe_n), 32'd1);
    checkOutput("reset dq", 32'(sram_dq), 32'h0000FFFF);
    checkOutput("reset ready", 32'(ready), 32'd1);
    checkOutput("tied ce/ub/lb", {29'd0, sram_ce_n, sram_ub_n, sram_lb_n}, 32'd0);
`ifdef SRAM_ADDR_CHECK_EN
    checkOutput("reset addr_err", 32'(addr_err), 32'd0);
`endif
    #2 rst = 1'b1;

    for (int i = 0; i < nvec; i++) begin
      if (!vecs[i].b2b) idleCycle();
      applyStimulus(i);
    end

    // Abort a store in the strobe cycle of its low phase.
    idleCycle();
    @(posedge clk);
    #1;
    mem_write = 1'b1;
    address   = 32'd1036;
    wdata     = 32'hA5A55A5A;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checkOutput("abort pre we_n", 32'(sram_we_n), 32'd0);
    checkOutput("abort pre dq", 32'(sram_dq), 32'h00005A5A);
    #1 rst = 1'b0;
    #1;
    checkOutput("abort we_n", 32'(sram_we_n), 32'd1);
    checkOutput("abort oe_n", 32'(sram_oe_n), 32'd1);
    checkOutput("abort dq", 32'(sram_dq), 32'h0000FFFF);
    checkOutput("abort rdata", rdata, 32'h0);
    mem_write = 1'b0;
    #1 rst = 1'b1;
    #1;
    checkOutput("abort ready", 32'(ready), 32'd1);

    addVec("ld_after_rst", 1'b1, 1'b0, 32'd1024, 32'h0, 18'h00000, 32'hDEADBEEF, 1'b0);
    idleCycle();
    applyStimulus(nvec - 1);

`ifdef SRAM_ADDR_CHECK_EN
    idleCycle();
    @(posedge clk);
    #1;
    mem_read = 1'b1;
    address  = 32'h0;
    @(negedge clk);
    checkOutput("oor c0 ready", 32'(ready), 32'd0);
    checkOutput("oor c0 we_n", 32'(sram_we_n), 32'd1);
    checkOutput("oor c0 oe_n", 32'(sram_oe_n), 32'd1);
    checkOutput("oor c0 addr_err", 32'(addr_err), 32'd0);
    @(negedge clk);
    checkOutput("oor c1 ready", 32'(ready), 32'd1);
    checkOutput("oor c1 addr_err", 32'(addr_err), 32'd1);
    checkOutput("oor c1 rdata", rdata, 32'h0);
    checkOutput("oor c1 we_n", 32'(sram_we_n), 32'd1);
    checkOutput("oor c1 oe_n", 32'(sram_oe_n), 32'd1);
    @(posedge clk);
    #1 mem_read = 1'b0;
    @(negedge clk);
    checkOutput("oor c2 addr_err", 32'(addr_err), 32'd0);
    checkOutput("oor c2 ready", 32'(ready), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
